// File: rtl/fifo_read_adapter.sv
// fifo_read_adapter
//
// Read-side adapter for the team FIFOs. It issues fifo_read_en, absorbs the
// FIFO's one-cycle registered data_out latency, and presents the words on a
// valid/ready stream through a 2-entry skid buffer. The adapter sustains one
// word per cycle with no bubbles under back-pressure. It also counts completed
// stream handshakes for debug and performance monitoring.
//
// Ports
//   read_clk     sole clock; all state updates on its rising edge
//   rst          synchronous, active-high reset (has priority over flush)
//   flush        synchronous discard of buffered and in-flight words
//   fifo_empty   FIFO empty flag
//   fifo_data    FIFO data_out; valid the cycle after an accepted read
//   fifo_read_en read request to the FIFO
//   m_data       stream data (head of skid buffer)
//   m_valid      stream valid
//   m_ready      stream ready from consumer
//   word_count   completed handshakes, modulo 2^cnt_width
//
// State
//   occ      | skid-buffer occupancy, 0..2 (buf0 is the head)
//   inflight | a read was issued last cycle; its word is on fifo_data now

module fifo_read_adapter #(
  parameter int width     = 8,
  parameter int cnt_width = 16
) (
  input  logic                 read_clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 fifo_empty,
  input  logic [width-1:0]     fifo_data,
  output logic                 fifo_read_en,
  output logic [width-1:0]     m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [cnt_width-1:0] word_count
);

  logic [1:0]       occ;
  logic             inflight;
  logic [width-1:0] buf0;
  logic [width-1:0] buf1;
  logic             pop;
  logic [2:0]       occ_sum;

  // Outputs are forced quiet while rst is high, even before the first edge
  // has cleared the registers.
  assign m_valid = !rst && (occ != 2'd0);
  assign m_data  = rst ? '0 : buf0;
  assign pop     = m_valid && m_ready;

  // Occupancy the buffer would reach if every outstanding word lands and the
  // current pop completes. A pop in this cycle frees a slot in time for the
  // word requested now, which is what keeps the stream bubble-free.
  assign occ_sum = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};

  assign fifo_read_en = !rst && !flush && !fifo_empty && (occ_sum < 3'd2);

  always_ff @(posedge read_clk) begin
    if (rst) begin
      occ        <= 2'd0;
      inflight   <= 1'b0;
      buf0       <= '0;
      buf1       <= '0;
      word_count <= '0;
    end else begin
      // A handshake coinciding with flush still counts as delivered.
      if (pop)
        word_count <= word_count + cnt_width'(1);

      if (flush) begin
        occ      <= 2'd0;
        inflight <= 1'b0;
      end else begin
        occ      <= occ_sum[1:0];
        inflight <= fifo_read_en;

        if (pop && (occ == 2'd2))
          buf0 <= buf1;

        // The landing word goes to the head when the head is (or is about
        // to become) free; otherwise it waits in buf1. When occ is 2 with a
        // pop, this write to buf1 lands behind the shift above.
        if (inflight) begin
          if ((occ == 2'd0) || ((occ == 2'd1) && pop))
            buf0 <= fifo_data;
          else
            buf1 <= fifo_data;
        end
      end
    end
  end

  // The issue rule keeps occupancy within the two slots.
  occ_bound_a : assert property (@(posedge read_clk) disable iff (rst)
                                 occ_sum <= 3'd2);

endmodule
